// File: rtl/mem_arbiter.sv
// Two-master access controller for the unified RAM: arbitrates, checks
// legality, drives the RAM and routes one-cycle-latency responses back.
module mem_arbiter #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0001_FFFF,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [1:0]  m0_mode,
    input  logic        m0_signed,
    output logic        m0_gnt,
    output logic        m0_resp,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [1:0]  m1_mode,
    input  logic        m1_signed,
    output logic        m1_gnt,
    output logic        m1_resp,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        ram_we,
    output logic [31:0] ram_r_addr,
    output logic [31:0] ram_w_addr,
    output logic [31:0] ram_w_data,
    output logic [1:0]  ram_write_mode,
    output logic [1:0]  ram_read_mode,
    output logic        ram_read_signed,
    input  logic [31:0] ram_r_data
);

    logic        last;
    logic        sel;
    logic        any_gnt;
    logic        drive;
    logic        legal;
    logic        misalign;
    logic [32:0] end_addr;

    logic        sel_we;
    logic        sel_signed;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [1:0]  sel_mode;

    logic        pend_v;
    logic        pend_id;
    logic        pend_err;
    logic        pend_ld;

    assign any_gnt = rst_n & (m0_req | m1_req);

    // On a conflict the master recorded in last loses (round-robin)
    always_comb begin
        sel = m1_req;
        if (m0_req && m1_req) begin
            sel = FIXED_PRIO ? 1'b1 : ~last;
        end
    end

    assign m0_gnt = any_gnt & ~sel;
    assign m1_gnt = any_gnt & sel;

    assign sel_we     = sel ? m1_we     : m0_we;
    assign sel_signed = sel ? m1_signed : m0_signed;
    assign sel_addr   = sel ? m1_addr   : m0_addr;
    assign sel_wdata  = sel ? m1_wdata  : m0_wdata;
    assign sel_mode   = sel ? m1_mode   : m0_mode;

    // end_addr is the last byte touched, kept 33 bits wide to avoid wrap
    always_comb begin
        end_addr = {1'b0, sel_addr};
        misalign = 1'b0;
        unique case (sel_mode)
            2'd0: begin
                misalign = 1'b0;
            end
            2'd1: begin
                end_addr = {1'b0, sel_addr} + 33'd1;
                misalign = &sel_addr[1:0];
            end
            2'd2: begin
                end_addr = {1'b0, sel_addr} + 33'd3;
                misalign = |sel_addr[1:0];
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

    assign legal = ~misalign & (end_addr <= {1'b0, ADDR_LIMIT});
    assign drive = any_gnt & legal;

    assign ram_we          = drive & sel_we;
    assign ram_r_addr      = drive ? sel_addr  : 32'h0;
    assign ram_w_addr      = drive ? sel_addr  : 32'h0;
    assign ram_w_data      = drive ? sel_wdata : 32'h0;
    assign ram_write_mode  = drive ? sel_mode  : 2'd2;
    assign ram_read_mode   = drive ? sel_mode  : 2'd2;
    assign ram_read_signed = drive & sel_signed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v   <= 1'b0;
            pend_id  <= 1'b0;
            pend_err <= 1'b0;
            pend_ld  <= 1'b0;
            last     <= 1'b1;
        end else begin
            pend_v   <= any_gnt;
            pend_id  <= sel;
            pend_err <= any_gnt & ~legal;
            pend_ld  <= drive & ~sel_we;
            if (any_gnt) begin
                last <= sel;
            end
        end
    end

    assign m0_resp  = pend_v & ~pend_id;
    assign m1_resp  = pend_v & pend_id;
    assign m0_err   = m0_resp & pend_err;
    assign m1_err   = m1_resp & pend_err;
    assign m0_rdata = (m0_resp && pend_ld) ? ram_r_data : 32'h0;
    assign m1_rdata = (m1_resp && pend_ld) ? ram_r_data : 32'h0;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master access controller for the unified data/instruction RAM. It accepts load/store requests from the instruction-fetch master (M0) and the load/store master (M1) and grants at most one per cycle. It checks alignment, range and mode before touching the RAM, drives the RAM's read/write, mode and sign controls, and routes each one-cycle-latency response back to the master that issued it. It sits between the core pipeline and the RAM and is the only block that drives the RAM ports.

## Interface
Parameters:
- `ADDR_LIMIT`, default 32'h0001_FFFF: highest legal byte address (RAM is 32768 x 32 bit).
- `FIXED_PRIO`, default 0: 0 = round-robin; 1 = M1 always wins a conflict.

Ports (x = 0, 1 for each master):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mx_req`  in  1  request valid; the master holds it and all request fields stable until `mx_gnt`.
- `mx_we`  in  1  1 = store, 0 = load.
- `mx_addr`  in  32  byte address.
- `mx_wdata`  in  32  store data, LSB-aligned.
- `mx_mode`  in  2  access size: 0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- `mx_signed`  in  1  sign-extend load data.
- `mx_gnt`  out  1  request accepted this cycle (combinational).
- `mx_resp`  out  1  one-cycle response pulse.
- `mx_rdata`  out  32  load data, valid only with `mx_resp`.
- `mx_err`  out  1  access was rejected, valid only with `mx_resp`.
- `ram_we`  out  1  RAM write enable.
- `ram_r_addr`  out  32  RAM read address.
- `ram_w_addr`  out  32  RAM write address.
- `ram_w_data`  out  32  RAM write data.
- `ram_write_mode`  out  2  RAM write size.
- `ram_read_mode`  out  2  RAM read size.
- `ram_read_signed`  out  1  RAM sign-extend select.
- `ram_r_data`  in  32  registered RAM read data.

## Operation
- **Arbitration.**
  - A single requester is granted immediately.
  - On a conflict with `FIXED_PRIO`=0, the master named by the `last` pointer loses. `last` updates to the granted master on every grant, and resets to 1 so that M0 wins the first conflict.
  - On a conflict with `FIXED_PRIO`=1, M1 wins.
  - At most one `gnt` is asserted per cycle.
- **Legality check** (combinational, on the selected request). The access is illegal if any of the following hold:
  - `mode`=3;
  - halfword with `addr[1:0]`=3;
  - word with `addr[1:0]`≠0;
  - `addr` > `ADDR_LIMIT`;
  - halfword with `addr`+1 > `ADDR_LIMIT`, or word with `addr`+3 > `ADDR_LIMIT`.
  
  An illegal request is still granted, but the RAM is driven idle.
- **RAM drive** (combinational from the granted, legal request).
  - `ram_we` = `we`.
  - Both `ram_r_addr` and `ram_w_addr` = `addr`; `ram_w_data` = `wdata`.
  - Both `ram_write_mode` and `ram_read_mode` = `mode`; `ram_read_signed` = `signed`.
  - **Idle drive** (no grant, illegal request, or `rst_n` low): `ram_we`=0, addresses 0, modes 2 (word), signed 0. The RAM then performs a harmless word read of address 0.
- **Response pipeline.** These registers are loaded on every edge:
  - `pend_v` = any grant;
  - `pend_id` = granted master;
  - `pend_err` = illegal;
  - `pend_ld` = !`we` && legal.
- **Response outputs.**
  - `mx_resp` = `pend_v` && (`pend_id`==x).
  - `mx_err` = `mx_resp` && `pend_err`.
  - `mx_rdata` = `ram_r_data` when `mx_resp` && `pend_ld`, else 0.
  - Stores and errors return `rdata`=0.
- **Pipelining.** Back-to-back grants are allowed every cycle. The response to cycle N's grant appears in cycle N+1, concurrently with cycle N+1's grant.

## Timing
- **Reset values:**
  - asynchronous clear of `pend_v`, `pend_id`, `pend_err`, `pend_ld`; `last`=1;
  - all `mx_resp`/`mx_err` = 0, `mx_rdata` = 0;
  - `mx_gnt`=0 and `ram_we`=0 while `rst_n`=0.
- **Latency:**
  - grant in cycle N (same cycle as request at earliest);
  - RAM write or read capture at the N→N+1 edge;
  - `mx_resp` high for exactly cycle N+1.
- **Stores:** the written word is visible to a load granted in cycle N+1. That load returns the new value in cycle N+2.
- **Throughput:** 1 access per cycle total. A losing master waits at most 1 cycle under round-robin with both masters continuously requesting.
- **Reset mid-operation:** a pending response is dropped with no pulse after reset. A write granted in the same cycle that `rst_n` falls is suppressed.
- **Requests after `gnt`:** a master may re-assert `req` with new fields in the cycle after its `gnt`, and may do so without waiting for `resp`.

## Test plan
- **Single load:** M0 loads word @0x10 with mem[4]=0xDEADBEEF. Required: `m0_gnt` in cycle N; `m0_resp`=1 with `rdata`=0xDEADBEEF in N+1; `m1_resp`=0.
- **Conflict:** M0 and M1 request together for 4 cycles (`FIXED_PRIO`=0, just after reset). Required grants M0, M1, M0, M1. Repeat with `FIXED_PRIO`=1: required grants M1 ×4, M0 never granted.
- **Signed/unsigned byte load:** M1 stores byte 0x80 @0x21 then signed-loads @0x21. Required load `rdata`=0xFFFFFF80; unsigned load returns 0x00000080; the other bytes of mem[8] are unchanged.
- **Illegal accesses:** word @0x2, halfword @0x7, `mode`=3, word @0x20000. Each is granted. Required: `resp` with `err`=1, `rdata`=0, `ram_we`=0 in the grant cycle, and memory unchanged.
- **Back-to-back RAW:** M1 stores word 0x12345678 @0x40 in N, loads @0x40 in N+1. Required load `resp` in N+2 with 0x12345678.
- **Reset mid-operation:** assert `rst_n`=0 in the cycle after a grant. Required: no `resp` pulse, all outputs 0. The first conflict after release grants M0.
